mynios2_onchip_loader: RTL and testbench

MYNIOS2_ONCHIP_LOADER -- requirements
Module: mynios2_onchip_loader

---
 rtl/mynios2_onchip_loader.sv | 218 +++++++++++++++++++++
 tb/tb_mynios2_onchip_loader.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mynios2_onchip_loader.sv
`default_nettype none
// ============================================================================
// Module : mynios2_onchip_loader
// Packs a byte stream little-endian into 32-bit words and writes them to an
// on-chip memory slave, keeping a running checksum. Optional read-back verify
// is compiled in when MYNIOS2_LOADER_VERIFY_EN is defined.
// Rev    : 1.0
// ============================================================================
module mynios2_onchip_loader #(
  parameter int DEPTH  = 1000,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [7:0]        st_data,
  input  logic              st_last,
  output logic [ADDR_W-1:0] mem_address,
  output logic [3:0]        mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [31:0]       mem_writedata,
  output logic              mem_clken,
  input  logic [31:0]       mem_readdata,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   word_count,
  output logic [31:0]       checksum,
  output logic              overflow,
  output logic              verify_err
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_VERIFY = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [ADDR_W+1:0] c_depth = (ADDR_W+2)'(DEPTH);
  localparam logic [ADDR_W:0]   c_one   = (ADDR_W+1)'(1);
`ifdef MYNIOS2_LOADER_VERIFY_EN
  localparam state_t c_load_exit = S_VERIFY;
`else
  localparam state_t c_load_exit = S_DONE;
`endif

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_base;
  logic [23:0]       r_pack;
  logic [1:0]        r_lane;
  logic              w_full;
  logic              w_accept;
  logic              w_word_done;
  logic [31:0]       w_word;
  logic [3:0]        w_be;

  // Next write address has run off the end of memory.
  assign w_full      = ({2'b00, r_base} + {1'b0, word_count}) >= c_depth;
  assign w_accept    = st_valid && st_ready;
  assign w_word_done = w_accept && ((r_lane == 2'd3) || st_last);
  // Unfilled upper lanes of r_pack are always zero, so OR-ing in the new byte is safe.
  assign w_word      = {8'h00, r_pack} | (32'(st_data) << {r_lane, 3'b000});

  always_comb begin
    w_be = 4'h1;
    case (r_lane)
      2'd0:    w_be = 4'h1;
      2'd1:    w_be = 4'h3;
      2'd2:    w_be = 4'h7;
      default: w_be = 4'hF;
    endcase
  end

  assign st_ready  = (r_state == S_LOAD) && !w_full;
  assign busy      = (r_state == S_LOAD) || (r_state == S_VERIFY);
  assign done      = (r_state == S_DONE);
  assign mem_clken = 1'b1;

`ifdef MYNIOS2_LOADER_VERIFY_EN
  logic [ADDR_W:0] r_vidx;
  logic [31:0]     r_vsum;
  logic [3:0]      r_last_be;
  logic            r_rd_v;
  logic            r_rd_last;
  logic            r_cap_v;
  logic            r_cap_last;
  logic [31:0]     w_vmask;
  logic [31:0]     w_vsum_next;

  assign w_vmask     = r_cap_last ? {{8{r_last_be[3]}}, {8{r_last_be[2]}},
                                     {8{r_last_be[1]}}, {8{r_last_be[0]}}} : 32'hFFFF_FFFF;
  assign w_vsum_next = r_vsum + (mem_readdata & w_vmask);
`else
  logic w_unused_rd;
  assign w_unused_rd = ^mem_readdata;
  assign verify_err  = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (start) w_next = S_LOAD;
      S_LOAD: begin
        if (w_full)                    w_next = S_DONE;
        else if (w_accept && st_last)  w_next = c_load_exit;
      end
`ifdef MYNIOS2_LOADER_VERIFY_EN
      S_VERIFY: if (r_cap_v && r_cap_last) w_next = S_DONE;
`else
      S_VERIFY: w_next = S_DONE;
`endif
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_base         <= '0;
      r_pack         <= '0;
      r_lane         <= '0;
      mem_address    <= '0;
      mem_byteenable <= '0;
      mem_chipselect <= 1'b0;
      mem_write      <= 1'b0;
      mem_writedata  <= '0;
      word_count     <= '0;
      checksum       <= '0;
      overflow       <= 1'b0;
`ifdef MYNIOS2_LOADER_VERIFY_EN
      verify_err     <= 1'b0;
      r_vidx         <= '0;
      r_vsum         <= '0;
      r_last_be      <= '0;
      r_rd_v         <= 1'b0;
      r_rd_last      <= 1'b0;
      r_cap_v        <= 1'b0;
      r_cap_last     <= 1'b0;
`endif
    end else begin
      mem_chipselect <= 1'b0;
      mem_write      <= 1'b0;
`ifdef MYNIOS2_LOADER_VERIFY_EN
      r_rd_v         <= 1'b0;
      r_rd_last      <= 1'b0;
      r_cap_v        <= r_rd_v;
      r_cap_last     <= r_rd_last;
`endif
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_base     <= base_addr;
            r_pack     <= '0;
            r_lane     <= '0;
            word_count <= '0;
            checksum   <= '0;
            overflow   <= 1'b0;
`ifdef MYNIOS2_LOADER_VERIFY_EN
            verify_err <= 1'b0;
            r_vidx     <= '0;
            r_vsum     <= '0;
`endif
          end
        end
        S_LOAD: begin
          if (w_full) begin
            overflow <= 1'b1;
          end else if (w_word_done) begin
            mem_chipselect <= 1'b1;
            mem_write      <= 1'b1;
            mem_address    <= r_base + word_count[ADDR_W-1:0];
            mem_byteenable <= w_be;
            mem_writedata  <= w_word;
            word_count     <= word_count + c_one;
            checksum       <= checksum + w_word;
            r_pack         <= '0;
            r_lane         <= '0;
`ifdef MYNIOS2_LOADER_VERIFY_EN
            r_last_be      <= w_be;
`endif
          end else if (w_accept) begin
            r_pack <= w_word[23:0];
            r_lane <= r_lane + 2'd1;
          end
        end
`ifdef MYNIOS2_LOADER_VERIFY_EN
        S_VERIFY: begin
          // Reads issue from registered outputs, so the first one lands after the final write.
          if (r_vidx < word_count) begin
            mem_chipselect <= 1'b1;
            mem_address    <= r_base + r_vidx[ADDR_W-1:0];
            r_rd_v         <= 1'b1;
            r_rd_last      <= (r_vidx + c_one) == word_count;
            r_vidx         <= r_vidx + c_one;
          end
          if (r_cap_v) begin
            r_vsum <= w_vsum_next;
            if (r_cap_last) verify_err <= (w_vsum_next != checksum);
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mynios2_onchip_loader.sv
`default_nettype none
// ============================================================================
// Module : tb_mynios2_onchip_loader
// Scoreboard bench: expected memory writes are queued from a byte-packing model
// and checked against the write port; status outputs checked after each load.
// Rev    : 1.0
// ============================================================================
module tb_mynios2_onchip_loader;
  localparam int DEPTH  = 1000;
  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic              st_valid = 1'b0;
  logic              st_ready;
  logic [7:0]        st_data = '0;
  logic              st_last = 1'b0;
  logic [ADDR_W-1:0] mem_address;
  logic [3:0]        mem_byteenable;
  logic              mem_chipselect;
  logic              mem_write;
  logic [31:0]       mem_writedata;
  logic              mem_clken;
  logic [31:0]       mem_readdata = '0;
  logic              busy;
  logic              done;
  logic [ADDR_W:0]   word_count;
  logic [31:0]       checksum;
  logic              overflow;
  logic              verify_err;

  always #5 clk = ~clk;

  mynios2_onchip_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
    .st_valid(st_valid), .st_ready(st_ready), .st_data(st_data), .st_last(st_last),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_clken(mem_clken), .mem_readdata(mem_readdata),
    .busy(busy), .done(done), .word_count(word_count), .checksum(checksum),
    .overflow(overflow), .verify_err(verify_err)
  );

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [3:0]        be;
    logic [31:0]       data;
  } wr_t;

  wr_t         exp_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          done_cnt = 0;
  int          rd_cnt = 0;
  logic [7:0]  stim [0:15];
  int          exp_wc;
  int          exp_acc;
  logic [31:0] exp_cs;
  bit          exp_ovf;
  bit          corrupt = 1'b0;
  logic [31:0] mem [0:DEPTH-1];

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Memory slave: byte-enabled writes, one-cycle registered reads, optional corruption of word 1.
  initial for (int i = 0; i < DEPTH; i++) mem[i] = '0;
  always @(posedge clk) begin
    if (mem_chipselect && mem_write && (int'(mem_address) < DEPTH))
      for (int k = 0; k < 4; k++)
        if (mem_byteenable[k]) mem[mem_address][8*k +: 8] <= mem_writedata[8*k +: 8];
    if (mem_chipselect && !mem_write && (int'(mem_address) < DEPTH))
      mem_readdata <= mem[mem_address] - ((corrupt && mem_address == 10'd1) ? 32'd1 : 32'd0);
  end

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (mem_chipselect && !mem_write) rd_cnt++;
    if (mem_chipselect && mem_write) begin
      check_eq("write_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        wr_t e;
        e = exp_q.pop_front();
        check_eq("wr_addr", 64'(mem_address), 64'(e.addr));
        check_eq("wr_be", 64'(mem_byteenable), 64'(e.be));
        check_eq("wr_data", 64'(mem_writedata), 64'(e.data));
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_st_ready"}, 64'(st_ready), 64'd0);
    check_eq({tag, "_cs"}, 64'(mem_chipselect), 64'd0);
    check_eq({tag, "_wr"}, 64'(mem_write), 64'd0);
    check_eq({tag, "_addr"}, 64'(mem_address), 64'd0);
    check_eq({tag, "_be"}, 64'(mem_byteenable), 64'd0);
    check_eq({tag, "_wdata"}, 64'(mem_writedata), 64'd0);
    check_eq({tag, "_clken"}, 64'(mem_clken), 64'd1);
    check_eq({tag, "_busy"}, 64'(busy), 64'd0);
    check_eq({tag, "_done"}, 64'(done), 64'd0);
    check_eq({tag, "_wc"}, 64'(word_count), 64'd0);
    check_eq({tag, "_csum"}, 64'(checksum), 64'd0);
    check_eq({tag, "_ovf"}, 64'(overflow), 64'd0);
    check_eq({tag, "_verr"}, 64'(verify_err), 64'd0);
  endtask

  // Reference packer: little-endian words, partial last word, stop at end of memory.
  task automatic build_expect(input int base, input int n);
    exp_wc = 0; exp_cs = '0; exp_ovf = 1'b0; exp_acc = 0;
    for (int w = 0; w * 4 < n; w++) begin
      wr_t e;
      if (base + w >= DEPTH) begin
        exp_ovf = 1'b1;
        break;
      end
      e.addr = ADDR_W'(base + w);
      e.be   = '0;
      e.data = '0;
      for (int k = 0; k < 4; k++)
        if (w * 4 + k < n) begin
          e.data[8*k +: 8] = stim[w*4 + k];
          e.be[k] = 1'b1;
          exp_acc++;
        end
      exp_q.push_back(e);
      exp_cs += e.data;
      exp_wc++;
    end
  endtask

  task automatic send(input int n, input bit use_last, input int gap_pct,
                      input int restart_at, output int nacc);
    nacc = 0;
    for (int i = 0; i < n; i++) begin
      bit got;
      int w;
      got = 1'b0;
      w = 0;
      if (gap_pct > 0 && int'($urandom_range(99, 0)) < gap_pct)
        repeat ($urandom_range(3, 1)) begin @(posedge clk); #1; end
      st_valid = 1'b1;
      st_data  = stim[i];
      st_last  = use_last && (i == n - 1);
      if (i == restart_at) begin
        start = 1'b1;
        base_addr = 10'd500;
      end
      while (!got && w < 20) begin
        @(negedge clk);
        got = st_ready;
        @(posedge clk); #1;
        start = 1'b0;
        w++;
      end
      st_valid = 1'b0;
      st_last  = 1'b0;
      if (!got) break;
      nacc++;
    end
  endtask

  task automatic run_load(input string name, input int base, input int n, input int gap_pct,
                          input int restart_at, input bit exp_verr);
    int nacc, d0, r0, t, exp_rd;
    build_expect(base, n);
    d0 = done_cnt;
    r0 = rd_cnt;
    base_addr = ADDR_W'(base);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    base_addr = ADDR_W'($urandom);
    send(n, 1'b1, gap_pct, restart_at, nacc);
    t = 0;
    while (done_cnt == d0 && t < 300) begin @(posedge clk); #1; t++; end
    repeat (3) @(posedge clk);
    #1;
`ifdef MYNIOS2_LOADER_VERIFY_EN
    exp_rd = exp_ovf ? 0 : exp_wc;
`else
    exp_rd = 0;
`endif
    check_eq({name, "_done_pulses"}, 64'(done_cnt - d0), 64'd1);
    check_eq({name, "_accepted"}, 64'(nacc), 64'(exp_acc));
    check_eq({name, "_writes_left"}, 64'(exp_q.size()), 64'd0);
    check_eq({name, "_wc"}, 64'(word_count), 64'(exp_wc));
    check_eq({name, "_csum"}, 64'(checksum), 64'(exp_cs));
    check_eq({name, "_ovf"}, 64'(overflow), 64'(exp_ovf));
    check_eq({name, "_reads"}, 64'(rd_cnt - r0), 64'(exp_rd));
    check_eq({name, "_verr"}, 64'(verify_err), 64'(exp_verr));
    check_eq({name, "_busy"}, 64'(busy), 64'd0);
    exp_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nacc;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals("reset");
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 16; i++) stim[i] = 8'(i + 1);
    run_load("full_words", 0, 8, 0, -1, 1'b0);
    check_eq("full_words_csum_const", 64'(checksum), 64'h0C0A0806);

    stim[0] = 8'hAA; stim[1] = 8'hBB; stim[2] = 8'hCC; stim[3] = 8'hDD; stim[4] = 8'hEE;
    run_load("partial", 10, 5, 0, -1, 1'b0);
    check_eq("partial_csum_const", 64'(checksum), 64'hDDCCBC98);

    for (int i = 0; i < 16; i++) stim[i] = 8'($urandom);
    run_load("overflow", 998, 12, 0, -1, 1'b0);
    run_load("base_oob", 1000, 4, 0, -1, 1'b0);

    // Reset after three bytes: the partial word must never reach memory.
    stim[0] = 8'h11; stim[1] = 8'h22; stim[2] = 8'h33;
    base_addr = 10'd50;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    send(3, 1'b0, 0, -1, nacc);
    check_eq("midrst_accepted", 64'(nacc), 64'd3);
    reset_n = 1'b0;
    @(negedge clk);
    check_reset_vals("midrst");
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check_eq("midrst_no_write", 64'(mem[50]), 64'd0);
    for (int i = 0; i < 5; i++) stim[i] = 8'(8'h40 + i);
    run_load("after_rst", 20, 5, 0, -1, 1'b0);

    for (int i = 0; i < 9; i++) stim[i] = 8'($urandom);
    run_load("nogap", 100, 9, 0, -1, 1'b0);
    run_load("gaps_restart", 100, 9, 40, 3, 1'b0);

`ifdef MYNIOS2_LOADER_VERIFY_EN
    for (int i = 0; i < 8; i++) stim[i] = 8'(i + 1);
    corrupt = 1'b1;
    run_load("verify_bad", 0, 8, 0, -1, 1'b1);
    corrupt = 1'b0;
    run_load("verify_ok", 0, 8, 0, -1, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
